cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through cache controller that drives the single-word-per-line `dataRam` array and owns the matching tag/valid store. It sits between the CPU load/store port and the main-memory port. It services read hits from the data array in one cycle, refills on read misses, and forwards every store to memory. Saturating hit/miss counters are provided for performance monitoring.

## Interface
- `INDEX_LENGTH`, 4, line index width; `CACHE_LINES` = 2**INDEX_LENGTH (derived, not overridable)
- `DATA_LENGTH`, 32, word width
- `ADDR_LENGTH`, 32, word address width; `TAG_LENGTH` = ADDR_LENGTH-INDEX_LENGTH
- `CNT_LENGTH`, 16, counter width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_i`  in  1  CPU request strobe, sampled only in IDLE
- `we_i`  in  1  1 = store, 0 = load
- `addr_i`  in  ADDR_LENGTH  word address; index = [INDEX_LENGTH-1:0], tag = upper bits
- `data_i`  in  DATA_LENGTH  store data
- `ready_o`  out  1  one-cycle completion pulse
- `data_o`  out  DATA_LENGTH  load data, valid while `ready_o` is high
- `busy_o`  out  1  high in every state except IDLE
- `ram_index_o`  out  INDEX_LENGTH  to data array index
- `ram_data_o`  out  DATA_LENGTH  to data array write data
- `ram_we_o`  out  1  to data array write enable (level; asserted for exactly one cycle)
- `ram_data_i`  in  DATA_LENGTH  from data array, combinational read of `ram_index_o`
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`, `mem_addr_o`, `mem_data_o`  out  1/ADDR_LENGTH/DATA_LENGTH  held stable with `mem_req_o`
- `mem_ack_i`  in  1  memory completion; `mem_data_i` valid in the same cycle for reads
- `mem_data_i`  in  DATA_LENGTH  refill data
- `hit_cnt_o`, `miss_cnt_o`  out  CNT_LENGTH  saturating counters

## Operation
- States: IDLE, COMPARE, REFILL, WRITE_MEM, RESPOND.
- IDLE:
  - On `req_i`, latch addr/we/data into request registers and go to COMPARE.
  - `req_i` in any other state is ignored and not queued.
- COMPARE:
  - `ram_index_o` = latched index.
  - hit = valid[index] && tag[index] == latched tag.
  - Read hit: `ready_o`=1, `data_o`=`ram_data_i`, hit_cnt++, go to IDLE.
  - Read miss: miss_cnt++, go to REFILL.
  - Write hit: `ram_we_o`=1 with latched data, hit_cnt++, go to WRITE_MEM.
  - Write miss: miss_cnt++, no allocate, go to WRITE_MEM.
- REFILL:
  - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=latched addr.
  - On `mem_ack_i`: `ram_we_o`=1 with `ram_data_o`=`mem_data_i`; set tag[index] and valid[index]; capture the word; go to RESPOND.
- WRITE_MEM:
  - `mem_req_o`=1, `mem_we_o`=1, latched addr/data.
  - On `mem_ack_i`, go to RESPOND.
- RESPOND: `ready_o`=1; `data_o` = captured refill word for loads, 0 for stores; go to IDLE.
- Counters saturate at all-ones and never wrap. Only COMPARE updates them.
- Reset value of every output is 0, and all valid bits are cleared.
- Asynchronous reset mid-operation:
  - Immediately return to IDLE and drop `mem_req_o`.
  - A refill interrupted before ack leaves that line invalid.
  - A late `mem_ack_i` arriving in IDLE is ignored.
- The data array contents are not reset; lines are gated by the valid bits.

## Timing
- Request accepted at edge 0 (IDLE, `req_i`=1); COMPARE is cycle 1.
- Read hit: `ready_o` in cycle 1, so latency is 1.
- Read miss: `mem_req_o` from cycle 2 until the ack cycle k (k≥2, zero-wait ack permitted in cycle 2); array write in cycle k; `ready_o` in cycle k+1.
- Store: array write (on hit) in cycle 1; `mem_req_o` from cycle 2 to ack cycle k; `ready_o` in cycle k+1.
- `busy_o` is high from cycle 1 through the `ready_o` cycle inclusive. The next request is accepted in the cycle after `ready_o`.
- `mem_*` outputs are registered-stable for the full request. `mem_req_o` falls in the cycle after the ack.
- `ram_we_o` is never high for more than one consecutive cycle.

## Structure
- Shared package `cache_pkg`:
  - state encoding localparams (IDLE=0, COMPARE=1, REFILL=2, WRITE_MEM=3, RESPOND=4)
  - default widths (INDEX_LENGTH, DATA_LENGTH, ADDR_LENGTH)
- One sub-module, `tagRam`:
  - CACHE_LINES × (TAG_LENGTH+1) array, combinational read
  - synchronous write
  - async clear of the valid bits on `rst`
- The data array stays external and connects through the `ram_*` ports.

## Test plan
- Reset, then load addr 0x15 → miss. `mem_req_o` asserts with addr 0x15. Ack in cycle 4 with 0xDEADBEEF → `ready_o` in cycle 5 with `data_o`=0xDEADBEEF; miss_cnt=1.
- Repeat load 0x15 → `ready_o` in cycle 1 with 0xDEADBEEF, no `mem_req_o`; hit_cnt=1.
- Load 0x25 (same index 5, different tag) → miss and refill with 0x12345678. A subsequent load of 0x15 misses again (eviction).
- Store 0x25 ← 0xA5A5A5A5 (hit) → `ram_we_o` in cycle 1, memory write with ack → `ready_o`. A following load of 0x25 hits with 0xA5A5A5A5. Store to uncached 0x30 → no `ram_we_o`.
- Assert `rst` while in REFILL before ack → `mem_req_o`=0 immediately; a late ack is ignored; the next load of the same address misses.
- With CNT_LENGTH=2, four consecutive hits → hit_cnt_o holds 3. `req_i` pulses while busy are ignored, so the transaction count equals the number of `ready_o` pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// default widths and the controller state encoding.
package cache_pkg;

    localparam int DEF_INDEX_LENGTH = 4;
    localparam int DEF_DATA_LENGTH  = 32;
    localparam int DEF_ADDR_LENGTH  = 32;
    localparam int DEF_CNT_LENGTH   = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COMPARE   = 3'd1;
    localparam logic [2:0] ST_REFILL    = 3'd2;
    localparam logic [2:0] ST_WRITE_MEM = 3'd3;
    localparam logic [2:0] ST_RESPOND   = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        COMPARE   = ST_COMPARE,
        REFILL    = ST_REFILL,
        WRITE_MEM = ST_WRITE_MEM,
        RESPOND   = ST_RESPOND
    } cache_state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Bus bundle of the cache controller: CPU load/store port, data-array port
// and main-memory port.
//
// Handshakes:
//   CPU    - req_i is sampled only while the controller is idle; the
//            request completes with a single-cycle ready_o pulse, with
//            data_o valid in that same cycle. Requests seen while busy_o
//            is high are dropped, not queued.
//   memory - mem_req_o together with mem_we_o/mem_addr_o/mem_data_o is
//            held stable until the cycle in which mem_ack_i is high; for
//            reads mem_data_i is valid in that ack cycle. mem_req_o falls
//            in the cycle after the ack.
//   array  - ram_data_i is a combinational read of ram_index_o; ram_we_o
//            writes ram_data_o at ram_index_o on the next rising edge.
interface cache_ctrl_if
    import cache_pkg::*;
#(
    parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
    parameter int DATA_LENGTH  = DEF_DATA_LENGTH,
    parameter int ADDR_LENGTH  = DEF_ADDR_LENGTH
);

    logic                    req_i;
    logic                    we_i;
    logic [ADDR_LENGTH-1:0]  addr_i;
    logic [DATA_LENGTH-1:0]  data_i;
    logic                    ready_o;
    logic [DATA_LENGTH-1:0]  data_o;
    logic                    busy_o;

    logic [INDEX_LENGTH-1:0] ram_index_o;
    logic [DATA_LENGTH-1:0]  ram_data_o;
    logic                    ram_we_o;
    logic [DATA_LENGTH-1:0]  ram_data_i;

    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [ADDR_LENGTH-1:0]  mem_addr_o;
    logic [DATA_LENGTH-1:0]  mem_data_o;
    logic                    mem_ack_i;
    logic [DATA_LENGTH-1:0]  mem_data_i;

    // Controller side
    modport slave (
        input  req_i, we_i, addr_i, data_i, ram_data_i, mem_ack_i, mem_data_i,
        output ready_o, data_o, busy_o, ram_index_o, ram_data_o, ram_we_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    // CPU / memory / array environment side
    modport master (
        output req_i, we_i, addr_i, data_i, ram_data_i, mem_ack_i, mem_data_i,
        input  ready_o, data_o, busy_o, ram_index_o, ram_data_o, ram_we_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/cache_ctrl_tag_ram.sv
// Tag/valid store of the cache: one tag and one valid bit per line,
// combinational read, synchronous write. Valid bits clear asynchronously
// on reset; tags are left as-is since they are gated by the valid bits.
module tagRam
    import cache_pkg::*;
#(
    parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
    parameter int TAG_LENGTH   = DEF_ADDR_LENGTH - DEF_INDEX_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_LENGTH-1:0] index,
    input  logic                    we,
    input  logic [TAG_LENGTH-1:0]   wtag,
    output logic                    valid,
    output logic [TAG_LENGTH-1:0]   tag
);

    localparam int CACHE_LINES = 1 << INDEX_LENGTH;

    logic [CACHE_LINES-1:0] valid_bits;
    logic [TAG_LENGTH-1:0]  tags [CACHE_LINES];

    // Valid bits: cleared by reset, set when a line is (re)filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (we) begin
            valid_bits[index] <= 1'b1;
        end
    end

    // Tag storage: written together with the valid bit on refill
    always_ff @(posedge clk) begin
        if (we) begin
            tags[index] <= wtag;
        end
    end

    assign valid = valid_bits[index];
    assign tag   = tags[index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller. Read hits complete in the
// compare cycle; read misses refill the single-word line from memory;
// every store is forwarded to memory (updating the array only on a hit,
// no write-allocate). Saturating hit/miss counters advance only in the
// compare cycle.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
    parameter int DATA_LENGTH  = DEF_DATA_LENGTH,
    parameter int ADDR_LENGTH  = DEF_ADDR_LENGTH,
    parameter int CNT_LENGTH   = DEF_CNT_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_ctrl_if.slave           bus,
    output logic [CNT_LENGTH-1:0] hit_cnt_o,
    output logic [CNT_LENGTH-1:0] miss_cnt_o,
    output cache_state_t          dbg_state
);

    localparam int TAG_LENGTH = ADDR_LENGTH - INDEX_LENGTH;
    localparam logic [CNT_LENGTH-1:0] CNT_ONE = {{(CNT_LENGTH-1){1'b0}}, 1'b1};

    cache_state_t state, state_nxt;

    // Latched request
    logic [ADDR_LENGTH-1:0] req_addr;
    logic                   req_we;
    logic [DATA_LENGTH-1:0] req_data;
    logic [DATA_LENGTH-1:0] fill_data;

    logic [CNT_LENGTH-1:0]  hit_cnt;
    logic [CNT_LENGTH-1:0]  miss_cnt;

    logic [INDEX_LENGTH-1:0] req_index;
    logic [TAG_LENGTH-1:0]   req_tag;
    logic                    line_valid;
    logic [TAG_LENGTH-1:0]   line_tag;
    logic                    hit;
    logic                    tag_we;

    // Combinational outputs of the FSM
    logic                   ready;
    logic [DATA_LENGTH-1:0] rdata;
    logic                   ram_we;
    logic [DATA_LENGTH-1:0] ram_wdata;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [DATA_LENGTH-1:0] mem_wdata;

    assign req_index = req_addr[INDEX_LENGTH-1:0];
    assign req_tag   = req_addr[ADDR_LENGTH-1:INDEX_LENGTH];
    assign hit       = line_valid && (line_tag == req_tag);

    // The tag store is only written when refill data arrives, so a refill
    // cut short by reset never marks the line valid.
    assign tag_we = (state == REFILL) && bus.mem_ack_i;

    tagRam #(
        .INDEX_LENGTH (INDEX_LENGTH),
        .TAG_LENGTH   (TAG_LENGTH)
    ) u_tag_ram (
        .clk   (clk),
        .rst   (rst),
        .index (req_index),
        .we    (tag_we),
        .wtag  (req_tag),
        .valid (line_valid),
        .tag   (line_tag)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        rdata     = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (bus.req_i) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (req_we) begin
                    if (hit) begin
                        ram_we    = 1'b1;
                        ram_wdata = req_data;
                    end
                    state_nxt = WRITE_MEM;
                end else if (hit) begin
                    ready     = 1'b1;
                    rdata     = bus.ram_data_i;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (bus.mem_ack_i) begin
                    ram_we    = 1'b1;
                    ram_wdata = bus.mem_data_i;
                    state_nxt = RESPOND;
                end
            end
            WRITE_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = req_data;
                if (bus.mem_ack_i) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                ready     = 1'b1;
                rdata     = req_we ? '0 : fill_data;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, taken only when a new request is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr <= '0;
            req_we   <= 1'b0;
            req_data <= '0;
        end else if ((state == IDLE) && bus.req_i) begin
            req_addr <= bus.addr_i;
            req_we   <= bus.we_i;
            req_data <= bus.data_i;
        end
    end

    // Refill word capture, replayed to the CPU in RESPOND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_data <= '0;
        end else if ((state == REFILL) && bus.mem_ack_i) begin
            fill_data <= bus.mem_data_i;
        end
    end

    // Saturating hit/miss counters, advanced once per request in COMPARE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == COMPARE) begin
            if (hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + CNT_ONE;
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.ready_o     = ready;
    assign bus.data_o      = rdata;
    assign bus.busy_o      = (state != IDLE);
    assign bus.ram_index_o = req_index;
    assign bus.ram_data_o  = ram_wdata;
    assign bus.ram_we_o    = ram_we;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_data_o  = mem_wdata;

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
    assign dbg_state  = state;

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl: directed scenarios plus randomized loads and
// stores against a cache/memory reference model (full-address line map,
// word-addressed memory image, saturating counters).
`timescale 1ns/1ps
module tb_cache_ctrl;
    import cache_pkg::*;

    localparam int IL    = 4;
    localparam int DL    = 32;
    localparam int AL    = 32;
    localparam int CL    = 2;
    localparam int LINES = 16;
    localparam int CMAX  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if #(.INDEX_LENGTH(IL), .DATA_LENGTH(DL), .ADDR_LENGTH(AL)) bus ();
    logic [CL-1:0] hit_cnt;
    logic [CL-1:0] miss_cnt;
    cache_state_t  dbg_state;

    cache_ctrl #(
        .INDEX_LENGTH (IL),
        .DATA_LENGTH  (DL),
        .ADDR_LENGTH  (AL),
        .CNT_LENGTH   (CL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt),
        .dbg_state  (dbg_state)
    );

    // External data array (not reset)
    logic [DL-1:0] dram [LINES];
    assign bus.ram_data_i = dram[bus.ram_index_o];
    always @(posedge clk) begin
        if (bus.ram_we_o) dram[bus.ram_index_o] <= bus.ram_data_o;
    end

    // Completion pulse counter
    int ready_pulses = 0;
    always @(negedge clk) begin
        if (bus.ready_o) ready_pulses++;
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    bit            m_valid [LINES];
    logic [AL-1:0] m_addr  [LINES];
    logic [DL-1:0] mem_m   [int unsigned];
    int            m_hits;
    int            m_misses;
    logic [DL-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DL-1:0] mem_word(input logic [AL-1:0] a);
        if (!mem_m.exists(a)) mem_m[a] = $urandom;
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // One CPU request, with the memory responder acking after 'delay'
    // wait cycles. 'noise' pulses req_i and scrambles the request inputs
    // while busy; all of that must be ignored.
    task automatic txn(input bit we, input logic [AL-1:0] addr,
                       input logic [DL-1:0] wdata, input int delay, input bit noise);
        int            idx;
        bit            exp_hit;
        logic [DL-1:0] rd_val;
        int            cyc, mem_first, ack_cyc, ready_cyc, we_cnt, we_cyc, wait_cnt;
        logic [DL-1:0] we_data;
        logic [IL-1:0] we_idx;
        logic [DL-1:0] got_data;
        bit            busy_bad, mem_bad;
        int            exp_lat;

        idx     = int'(addr[IL-1:0]);
        exp_hit = m_valid[idx] && (m_addr[idx] == addr);
        rd_val  = mem_word(addr);
        exp_q.push_back(we ? '0 : rd_val);

        bus.req_i  = 1'b1;
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.data_i = wdata;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        if (noise) begin
            bus.we_i   = ~we;
            bus.addr_i = $urandom;
            bus.data_i = $urandom;
        end

        cyc = 1; mem_first = 0; ack_cyc = 0; ready_cyc = 0;
        we_cnt = 0; we_cyc = 0; wait_cnt = 0; we_data = '0; we_idx = '0;
        got_data = '0; busy_bad = 1'b0; mem_bad = 1'b0;
        while (ready_cyc == 0 && cyc <= 40) begin
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                if (mem_first == 0) mem_first = cyc;
                if (bus.mem_addr_o !== addr || bus.mem_we_o !== we) mem_bad = 1'b1;
                if (we && bus.mem_data_o !== wdata) mem_bad = 1'b1;
                if (wait_cnt == delay) begin
                    bus.mem_ack_i = 1'b1;
                    ack_cyc = cyc;
                    if (we) begin
                        bus.mem_data_i = $urandom;
                        mem_m[addr] = bus.mem_data_o;
                    end else begin
                        bus.mem_data_i = rd_val;
                    end
                end
                wait_cnt++;
            end
            #1;
            if (bus.ram_we_o) begin
                we_cnt++;
                we_cyc  = cyc;
                we_data = bus.ram_data_o;
                we_idx  = bus.ram_index_o;
            end
            if (bus.ready_o) begin
                ready_cyc = cyc;
                got_data  = bus.data_o;
            end
            if (!bus.busy_o) busy_bad = 1'b1;
            if (noise) bus.req_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.mem_ack_i = 1'b0;
        bus.req_i     = 1'b0;

        if (ready_cyc == 0) begin
            check("ready_timeout", 0, 1);
            do_reset();
            return;
        end

        exp_lat = (exp_hit && !we) ? 1 : ack_cyc + 1;
        check("latency", ready_cyc, exp_lat);
        check("mem_req_start", mem_first, (exp_hit && !we) ? 0 : 2);
        if (mem_first != 0) check("mem_stable", mem_bad, 0);
        check("data_o", got_data, exp_q.pop_front());
        check("busy_during", busy_bad, 0);
        check("ram_we_count", we_cnt, ((we && exp_hit) || (!we && !exp_hit)) ? 1 : 0);
        if (we_cnt == 1) begin
            check("ram_we_cycle", we_cyc, we ? 1 : ack_cyc);
            check("ram_we_data", we_data, we ? wdata : rd_val);
            check("ram_we_index", we_idx, addr[IL-1:0]);
        end
        check("idle_after", {bus.busy_o, bus.ready_o, bus.mem_req_o}, 0);

        if (!we && !exp_hit) begin
            m_valid[idx] = 1'b1;
            m_addr[idx]  = addr;
        end
        if (exp_hit) begin
            if (m_hits < CMAX) m_hits++;
        end else begin
            if (m_misses < CMAX) m_misses++;
        end
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
        n_txn++;
    endtask

    // Reset while a refill is outstanding, then deliver a late ack in IDLE.
    task automatic reset_in_refill(input logic [AL-1:0] addr);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = addr;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        @(posedge clk);
        #1;
        check("refill_req", bus.mem_req_o, 1);
        rst = 1'b1;
        #1;
        check("rst_drops_req", bus.mem_req_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = 32'hBAD0BAD0;
        #1;
        check("late_ack_ready", bus.ready_o, 0);
        check("late_ack_ram_we", bus.ram_we_o, 0);
        @(posedge clk);
        #1;
        bus.mem_ack_i = 1'b0;
        check("late_ack_idle", {bus.busy_o, bus.ready_o, bus.mem_req_o}, 0);
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i      = 1'b0;
        bus.we_i       = 1'b0;
        bus.addr_i     = '0;
        bus.data_i     = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        for (int i = 0; i < LINES; i++) dram[i] = $urandom;
        model_reset();

        // Reset values
        #12;
        check("rst_ready", bus.ready_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_busy0", bus.busy_o, 0);
        check("rst_ram", {bus.ram_we_o, bus.ram_index_o, bus.ram_data_o}, 0);
        check("rst_mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o}, 0);
        check("rst_cnt", {hit_cnt, miss_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Miss / hit / eviction / store hit / store miss
        mem_m[32'h15] = 32'hDEADBEEF;
        mem_m[32'h25] = 32'h12345678;
        txn(1'b0, 32'h15, '0, 2, 1'b0);
        txn(1'b0, 32'h15, '0, 0, 1'b0);
        txn(1'b0, 32'h25, '0, 1, 1'b0);
        txn(1'b0, 32'h15, '0, 0, 1'b0);
        txn(1'b0, 32'h25, '0, 3, 1'b0);
        txn(1'b1, 32'h25, 32'hA5A5A5A5, 1, 1'b0);
        txn(1'b0, 32'h25, '0, 0, 1'b0);
        check("store_hit_data", bus.ram_data_i, 32'hA5A5A5A5);
        txn(1'b1, 32'h30, 32'h0BADF00D, 0, 1'b0);
        txn(1'b0, 32'h30, '0, 2, 1'b0);

        // Reset during refill
        reset_in_refill(32'h3A);
        txn(1'b0, 32'h3A, '0, 0, 1'b0);

        // Counter saturation with busy-time request noise
        do_reset();
        txn(1'b0, 32'h07, '0, 1, 1'b1);
        for (int i = 0; i < 4; i++) txn(1'b0, 32'h07, '0, 0, 1'b1);
        check("hit_sat", hit_cnt, 3);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            if (n % 90 == 89) do_reset();
            txn(1'($urandom_range(0, 1)), AL'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        @(posedge clk);
        #1;
        check("ready_pulses", ready_pulses, n_txn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
